// File: rtl/mem_access_unit.sv
// mem_access_unit: multi-cycle load/store unit for a word-only memory bus.
// Sub-word stores are done as read-modify-write; loads are sign/zero extended.
module mem_access_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  iClk,
  input  logic                  iRstN,
  input  logic                  iValid,
  input  logic [3:0]            iMemControl,
  input  logic [ADDR_WIDTH-1:0] iAddr,
  input  logic [31:0]           iWriteData,
  output logic                  oReady,
  output logic                  oDone,
  output logic [31:0]           oReadData,
  output logic                  oMisaligned,
  output logic                  oBusReq,
  output logic                  oBusWe,
  output logic [ADDR_WIDTH-1:0] oBusAddr,
  output logic [31:0]           oBusWData,
  input  logic                  iBusAck,
  input  logic [31:0]           iBusRData
);

  localparam logic [3:0] LW  = 4'b0000;
  localparam logic [3:0] LH  = 4'b0001;
  localparam logic [3:0] LB  = 4'b0010;
  localparam logic [3:0] LHU = 4'b0011;
  localparam logic [3:0] LBU = 4'b0100;
  localparam logic [3:0] SW  = 4'b0101;
  localparam logic [3:0] SH  = 4'b0110;
  localparam logic [3:0] SB  = 4'b0111;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t      state, state_next;
  logic [3:0]  code;
  logic [1:0]  lane;
  logic [15:0] store_data;
  logic        accept;
  logic        req_none;
  logic        req_misaligned;
  logic        subword_store;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_result;
  logic [31:0] merged;

  assign oReady        = (state == IDLE);
  assign accept        = iValid && (state == IDLE);
  assign req_none      = iMemControl[3];
  assign subword_store = (code == SH) || (code == SB);

  always_comb begin
    req_misaligned = 1'b0;
    case (iMemControl)
      LW, SW:      req_misaligned = (iAddr[1:0] != 2'b00);
      LH, LHU, SH: req_misaligned = iAddr[0];
      default:     req_misaligned = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_none || req_misaligned) state_next = DONE;
          else if (iMemControl == SW)     state_next = WRITE;
          else                            state_next = READ;
        end
      end
      READ:    if (iBusAck) state_next = subword_store ? WRITE : DONE;
      WRITE:   if (iBusAck) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    byte_sel = 8'h00;
    case (lane)
      2'd0:    byte_sel = iBusRData[7:0];
      2'd1:    byte_sel = iBusRData[15:8];
      2'd2:    byte_sel = iBusRData[23:16];
      default: byte_sel = iBusRData[31:24];
    endcase
    half_sel = lane[1] ? iBusRData[31:16] : iBusRData[15:0];

    load_result = 32'h0;
    case (code)
      LW:      load_result = iBusRData;
      LH:      load_result = {{16{half_sel[15]}}, half_sel};
      LHU:     load_result = {16'h0, half_sel};
      LB:      load_result = {{24{byte_sel[7]}}, byte_sel};
      LBU:     load_result = {24'h0, byte_sel};
      default: load_result = 32'h0;
    endcase

    // Untouched lanes keep the value just read from memory.
    merged = iBusRData;
    if (code == SB) begin
      case (lane)
        2'd0:    merged[7:0]   = store_data[7:0];
        2'd1:    merged[15:8]  = store_data[7:0];
        2'd2:    merged[23:16] = store_data[7:0];
        default: merged[31:24] = store_data[7:0];
      endcase
    end else if (code == SH) begin
      if (lane[1]) merged[31:16] = store_data;
      else         merged[15:0]  = store_data;
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state       <= IDLE;
      code        <= 4'b1000;
      lane        <= 2'b00;
      store_data  <= 16'h0;
      oDone       <= 1'b0;
      oMisaligned <= 1'b0;
      oBusReq     <= 1'b0;
      oBusWe      <= 1'b0;
      oReadData   <= 32'h0;
      oBusAddr    <= '0;
      oBusWData   <= 32'h0;
    end else begin
      state       <= state_next;
      oDone       <= (state_next == DONE);
      oMisaligned <= accept && !req_none && req_misaligned;
      oBusReq     <= (state_next == READ) || (state_next == WRITE);
      oBusWe      <= (state_next == WRITE);
      if (accept) begin
        code       <= iMemControl;
        lane       <= iAddr[1:0];
        store_data <= iWriteData[15:0];
        oBusAddr   <= {iAddr[ADDR_WIDTH-1:2], 2'b00};
        oBusWData  <= iWriteData;
        oReadData  <= 32'h0;
      end
      if ((state == READ) && iBusAck) begin
        if (subword_store) oBusWData <= merged;
        else               oReadData <= load_result;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a delayed-ack memory model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic [3:0]  ctrl = 4'b1000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        ready, done, mis, bus_req, bus_we;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic        ack = 1'b0;
  logic [31:0] bus_rdata = 32'h0;

  mem_access_unit #(.ADDR_WIDTH(32)) dut (
    .iClk(clk), .iRstN(rst_n), .iValid(valid), .iMemControl(ctrl),
    .iAddr(addr), .iWriteData(wdata), .oReady(ready), .oDone(done),
    .oReadData(rdata), .oMisaligned(mis), .oBusReq(bus_req), .oBusWe(bus_we),
    .oBusAddr(bus_addr), .oBusWData(bus_wdata), .iBusAck(ack), .iBusRData(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic        mis;
    int          lat;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  exp_t        exp_q[$];
  beat_t       beat_q[$];
  logic [31:0] mem [0:1023];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          acc = 0;
  int          ack_dly = 0;
  int          wait_cnt = 0;
  int          writes_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Done monitor: pops the scoreboard each time the unit reports completion.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done: got done=1 expected no completion");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("read_data", rdata, e.rd);
        check("misaligned", {31'h0, mis}, {31'h0, e.mis});
        check("latency", cyc - acc + 1, e.lat);
      end
    end
  end

  // Memory responder: acks after ack_dly waiting cycles and checks each beat.
  always @(negedge clk) begin
    if (ack) begin
      ack = 1'b0;
      wait_cnt = 0;
    end
    if (!bus_req) begin
      wait_cnt = 0;
    end else if (!ack) begin
      if (wait_cnt >= ack_dly) begin
        ack = 1'b1;
        bus_rdata = mem[bus_addr[11:2]];
        if (bus_we) writes_seen++;
        if (beat_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_beat: got we=%0b addr=%h expected no bus beat", bus_we, bus_addr);
        end else begin
          beat_t b;
          b = beat_q.pop_front();
          check("beat_we", {31'h0, bus_we}, {31'h0, b.we});
          check("beat_addr", bus_addr, b.addr);
          if (b.we) check("beat_wdata", bus_wdata, b.data);
        end
        if (bus_we) mem[bus_addr[11:2]] = bus_wdata;
      end else begin
        wait_cnt++;
      end
    end
  end

  task automatic push_beat(input logic we, input logic [31:0] a, input logic [31:0] d);
    beat_q.push_back('{we, a, d});
  endtask

  task automatic do_req(input logic [3:0] c, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_mis, input int lat);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    exp_q.push_back('{exp_rd, exp_mis, lat});
    ctrl = c; addr = a; wdata = wd; valid = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    valid = 1'b0; ctrl = 4'b1000;
    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL done_timeout: got no done expected done for code %b addr %h", c, a);
      exp_q.delete();
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[32'h100 >> 2] = 32'h80FF7F01;
    mem[32'h200 >> 2] = 32'h80011234;

    repeat (2) @(negedge clk);
    check("rst_ready", {31'h0, ready}, 32'h1);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_busreq", {31'h0, bus_req}, 32'h0);
    check("rst_bus_we", {31'h0, bus_we}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_bus_wdata", bus_wdata, 32'h0);
    rst_n = 1'b1;

    // Byte and half lanes, sign vs zero extension.
    ack_dly = 0;
    push_beat(1'b0, 32'h100, 32'h0); do_req(4'b0010, 32'h103, 32'h0, 32'hFFFFFF80, 1'b0, 2);
    push_beat(1'b0, 32'h100, 32'h0); do_req(4'b0100, 32'h103, 32'h0, 32'h00000080, 1'b0, 2);
    push_beat(1'b0, 32'h100, 32'h0); do_req(4'b0010, 32'h100, 32'h0, 32'h00000001, 1'b0, 2);
    push_beat(1'b0, 32'h100, 32'h0); do_req(4'b0010, 32'h101, 32'h0, 32'h0000007F, 1'b0, 2);
    push_beat(1'b0, 32'h100, 32'h0); do_req(4'b0010, 32'h102, 32'h0, 32'hFFFFFFFF, 1'b0, 2);
    push_beat(1'b0, 32'h100, 32'h0); do_req(4'b0001, 32'h100, 32'h0, 32'h00007F01, 1'b0, 2);

    ack_dly = 3;
    push_beat(1'b0, 32'h200, 32'h0); do_req(4'b0001, 32'h202, 32'h0, 32'hFFFF8001, 1'b0, 5);
    push_beat(1'b0, 32'h200, 32'h0); do_req(4'b0011, 32'h202, 32'h0, 32'h00008001, 1'b0, 5);

    // Sub-word read-modify-write, each on the original word.
    ack_dly = 0;
    mem[32'h40 >> 2] = 32'h11223344;
    push_beat(1'b0, 32'h40, 32'h0); push_beat(1'b1, 32'h40, 32'h1122AA44);
    do_req(4'b0111, 32'h41, 32'h000000AA, 32'h0, 1'b0, 3);
    mem[32'h40 >> 2] = 32'h11223344;
    push_beat(1'b0, 32'h40, 32'h0); push_beat(1'b1, 32'h40, 32'hBEEF3344);
    do_req(4'b0110, 32'h42, 32'h0000BEEF, 32'h0, 1'b0, 3);

    push_beat(1'b1, 32'h44, 32'hDEADBEEF); do_req(4'b0101, 32'h44, 32'hDEADBEEF, 32'h0, 1'b0, 2);
    push_beat(1'b0, 32'h44, 32'h0);        do_req(4'b0000, 32'h44, 32'h0, 32'hDEADBEEF, 1'b0, 2);

    // Rejected and no-op codes never touch the bus.
    do_req(4'b0000, 32'h102, 32'h0, 32'h0, 1'b1, 1);
    do_req(4'b0110, 32'h101, 32'h1234, 32'h0, 1'b1, 1);
    do_req(4'b1000, 32'h103, 32'h0, 32'h0, 1'b0, 1);
    do_req(4'b1111, 32'h103, 32'h0, 32'h0, 1'b0, 1);

    // Reset during the read beat of an SB abandons it with no write.
    ack_dly = 5;
    writes_seen = 0;
    @(negedge clk);
    ctrl = 4'b0111; addr = 32'h41; wdata = 32'h55; valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0; ctrl = 4'b1000;
    repeat (2) @(negedge clk);
    check("mid_read_busreq", {31'h0, bus_req}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busreq", {31'h0, bus_req}, 32'h0);
    check("rst_mid_ready", {31'h0, ready}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("no_write_after_rst", writes_seen, 0);

    ack_dly = 0;
    push_beat(1'b0, 32'h100, 32'h0); do_req(4'b0000, 32'h100, 32'h0, 32'h80FF7F01, 1'b0, 2);

    repeat (3) @(negedge clk);
    check("pending_done", exp_q.size(), 0);
    check("pending_beats", beat_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Multi-cycle load/store unit between the core datapath and a word-only data-memory bus. It is the consumer of the 4-bit memory-control code issued by control decode. It performs word, half and byte accesses, with sign or zero extension on loads. Memory has no byte enables, so sub-word stores are done as read-modify-write. It sits in the memory stage and stalls the pipeline through a ready/done handshake.

## Interface
- ADDR_WIDTH, 32, byte-address width; data width is fixed at 32.
- iClk  input  1  clock; all state changes on the rising edge.
- iRstN  input  1  reset; asynchronous, active-low.
- iValid  input  1  request strobe; accepted only when oReady=1.
- iMemControl  input  4  access code: 0000 LW, 0001 LH, 0010 LB, 0011 LHU, 0100 LBU, 0101 SW, 0110 SH, 0111 SB, 1000 none. 1001–1111 behave as none.
- iAddr  input  ADDR_WIDTH  byte address.
- iWriteData  input  32  store data; low byte or half is used for SB/SH.
- oReady  output  1  high in IDLE only.
- oDone  output  1  one-cycle pulse when the request completes.
- oReadData  output  32  extended load result; valid while oDone=1.
- oMisaligned  output  1  pulses with oDone when an access is rejected for alignment.
- oBusReq  output  1  bus request; held high until ack.
- oBusWe  output  1  1 = write, 0 = read; valid while oBusReq=1.
- oBusAddr  output  ADDR_WIDTH  word address (iAddr with [1:0] forced to 0).
- oBusWData  output  32  write word.
- iBusAck  input  1  completes the current bus beat when sampled high with oBusReq=1.
- iBusRData  input  32  read word; valid in the cycle iBusAck=1 on a read.

## Operation
- States: IDLE, READ, WRITE, DONE.
- Acceptance:
  - Acceptance happens on the edge where iValid=1 and the state is IDLE.
  - At acceptance the unit latches the code, address, write data and lane bits addr[1:0].
- Alignment check at acceptance:
  - LW/SW require addr[1:0]=00.
  - LH/LHU/SH require addr[0]=0.
  - Byte accesses are always aligned.
  - A misaligned request goes IDLE->DONE with oMisaligned=1, oReadData=0 and no bus activity.
- Code none or 1001–1111: IDLE->DONE, oReadData=0, oMisaligned=0, no bus activity.
- Loads: IDLE->READ->DONE.
  - Lane select for bytes: lane k = bits [8k+7:8k], k=addr[1:0].
  - Lane select for halves: addr[1]=0 selects [15:0], addr[1]=1 selects [31:16].
  - LB/LH sign-extend. LBU/LHU zero-extend. LW passes the word through.
  - The result is registered on the ack edge.
- SW: IDLE->WRITE->DONE, oBusWData=iWriteData.
- SB/SH: IDLE->READ->WRITE->DONE.
  - On the read ack, the unit merges the store byte or half into the selected lane of iBusRData.
  - Other lanes are left unchanged, and the merged word is written back to the same word address.
- READ and WRITE:
  - oBusReq=1, oBusWe=0 in READ and 1 in WRITE.
  - Address and data stay stable until ack.
  - The state is held indefinitely while iBusAck=0. There is no timeout.
- DONE: oDone=1 for exactly one cycle, then IDLE.
- iValid while oReady=0 is ignored; it is not queued.
- iBusAck while oBusReq=0 is ignored.

## Timing
- Reset (iRstN=0, immediate, regardless of state):
  - State goes to IDLE.
  - oReady=1.
  - oDone, oMisaligned, oBusReq and oBusWe are 0.
  - oReadData, oBusAddr and oBusWData are 0.
- Reset mid-transaction drops oBusReq immediately and abandons the access. Sub-word stores interrupted after the read beat perform no write.
- All outputs are registered, except oReady, which is decoded from state.
- Accept at edge T: oBusReq rises after T.
- Minimum latency, accept edge to oDone high, with ack in the first request cycle:
  - Loads and SW: 2 cycles.
  - SB/SH: 3 cycles.
  - Misaligned or none: 1 cycle.
- Each cycle of ack delay adds one cycle per beat.
- For SB/SH, oBusReq is deasserted for 0 cycles between the read and write beats: it stays high and oBusWe toggles 0->1 on the read-ack edge.
- A back-to-back request can be accepted on the edge after oDone, when the unit is in IDLE.

## Test plan
- LB and LBU at the same byte: bus word 0x80FF7F01.
  - LB at addr 0x103 -> oReadData 0xFFFFFF80, oBusAddr 0x100, oDone 2 cycles after accept.
  - LBU at 0x103 -> 0x00000080.
- LH, then LHU, with ack delayed 3 cycles: bus word 0x8001_1234.
  - LH at 0x202 -> 0xFFFF8001.
  - LHU at 0x202 -> 0x00008001.
  - oBusReq stays high for 4 cycles, oDone at accept+5.
- SB read-modify-write: memory word 0x11223344 at 0x40, SB addr 0x41, data 0xAA.
  - Read beat, then write beat with oBusWData 0x1122AA44.
  - SH at 0x42, data 0xBEEF -> write 0xBEEF3344 (applied to the original word).
- Misaligned accesses:
  - LW at 0x102 -> oDone and oMisaligned at accept+1, oBusReq never asserted.
  - SH at 0x101 -> same behaviour.
- Code 1000 and code 1111 -> oDone at accept+1, oReadData 0, no bus activity.
- Reset during the SB read beat:
  - Drive iRstN low mid-READ -> oBusReq low immediately, oReady=1, no write beat follows.
  - A subsequent LW completes normally.
